keysched_seq: RTL and testbench
===============================

// Module: keysched_seq
// PURPOSE
//  Iterative AES key-schedule sequencer. Accepts a cipher key and produces one expanded word
//  w[i] per cycle through a single shared g()/SubWord datapath (4 sbox instances), storing
//  all NB*(NR+1) words in an internal round-key buffer. Sits between the key-load interface
//  and the round datapath, which reads one full round key per request.
// PARAMETERS
//  WORD  32  word width in bits; fixed at 32
//  NB    4   words per round key; fixed at 4
//  NK    4   key length in words: 4, 6 or 8 (AES-128/192/256); other values are illegal
//  (localparams) NR = NK+6 rounds; TOTW = NB*(NR+1) words (44/52/60)
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          asynchronous active-low reset
//  i_key_valid   in   1          key offered this cycle
//  i_key         in   NK*WORD    cipher key; w[0] in MSBs (FIPS-197 byte order)
//  o_key_ready   out  1          key accepted when i_key_valid && o_key_ready
//  o_busy        out  1          expansion in progress
//  o_keys_valid  out  1          round-key buffer complete and readable
//  i_rk_rd       in   1          round-key read request
//  i_rk_idx      in   4          round number 0..NR
//  o_rk_valid    out  1          one-cycle pulse: o_rk holds requested key
//  o_rk          out  NB*WORD    {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in MSBs
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE, o_key_ready=1, o_busy=0, o_keys_valid=0, o_rk_valid=0,
//   o_rk=0, word counter i=0, rcon=8'h01. Buffer contents are not cleared.
//  FSM states: IDLE, EXPAND, DONE.
//   IDLE:   o_key_ready=1. On accept: write w[0..NK-1] from i_key, set i=NK, rcon=8'h01,
//           go to EXPAND.
//   EXPAND: o_key_ready=0, o_busy=1. Each cycle write w[i]=f(w[i-1])^w[i-NK], then i<=i+1.
//           f selection:
//            - i%NK==0: SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon<=xtime(rcon)
//              (sequence 01,02,04,...,80,1b,36).
//            - NK==8 && i%NK==4: SubWord(w[i-1]).
//            - otherwise: w[i-1].
//           After the cycle that writes w[TOTW-1], go to DONE.
//   DONE:   o_keys_valid=1, o_key_ready=1, o_busy=0. A new key accept behaves as in IDLE;
//           o_keys_valid=0 from the following cycle.
//  Latency: acceptance at edge k -> o_keys_valid=1 at edge k+(TOTW-NK), i.e. 40/46/52 cycles.
//  i%NK and i/NK are tracked by incrementing counters; no divider.
//  Reads:
//   - i_rk_rd with o_keys_valid=1 and i_rk_idx<=NR -> o_rk updates at the next edge and
//     o_rk_valid pulses for 1 cycle. Back-to-back reads are allowed, one per cycle.
//   - A read with o_keys_valid=0, or with i_rk_idx>NR, is ignored: o_rk_valid=0, o_rk holds.
//   - A read in the same cycle as a new key accept in DONE returns the old key; the buffer is
//     overwritten only at that edge.
//  i_key_valid during EXPAND is not accepted; the offering side must hold it.
//  Reset mid-EXPAND: return to IDLE immediately with o_keys_valid=0. The next key restarts
//   expansion from i=NK.
// TESTING
//  T1 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c -> o_keys_valid after 40 cycles;
//     rk0=2b7e1516..., rk1=a0fafe1788542cb123a339392a6c7605,
//     rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
//  T2 NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> latency 46;
//     w[6]=fe0c91f7, w[51]=01002202.
//  T3 NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> latency 52;
//     w[8]=9ba35411, w[12]=a8b09c1a (SubWord path),
//     rk14=fe4890d1e6188d0b046df344706c631e.
//  T4 Read before done / idx=11 with NK=4 -> o_rk_valid stays 0 and o_rk unchanged;
//     reads of idx 0..10 on consecutive cycles -> 11 consecutive valid pulses.
//  T5 In DONE, apply a second key with a simultaneous read of idx 10 -> old rk10 is returned;
//     o_keys_valid drops next cycle; new keys are correct after 40 cycles.
//  T6 Assert rst at EXPAND cycle 20, then apply T1 key -> outputs reset asynchronously;
//     T1 results reproduced exactly.

Source files
------------

// File: rtl/keysched_seq.sv
`default_nettype none
// ============================================================================
//  Module   : keysched_seq
//  Purpose  : Iterative AES key-schedule sequencer. Loads a 128/192/256-bit
//             cipher key and generates one expanded word w[i] per cycle
//             through a single shared RotWord/SubWord/Rcon datapath (four
//             S-box evaluations), filling a round-key buffer of NB*(NR+1)
//             words. The round datapath then reads one full round key per
//             request.
//  Ports    : clk            rising-edge clock
//             rst            asynchronous active-low reset
//             i_key_valid    key offered this cycle
//             i_key          cipher key, w[0] in the MSBs
//             o_key_ready    key accepted when i_key_valid && o_key_ready
//             o_busy         expansion in progress
//             o_keys_valid   round-key buffer complete and readable
//             i_rk_rd        round-key read request
//             i_rk_idx       round number 0..NR
//             o_rk_valid     one-cycle pulse, o_rk holds the requested key
//             o_rk           {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in MSBs
//  Revision : 1.0  initial release
// ============================================================================
module keysched_seq #(
  parameter int WORD = 32,
  parameter int NB   = 4,
  parameter int NK   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_key_valid,
  input  logic [NK*WORD-1:0]   i_key,
  output logic                 o_key_ready,
  output logic                 o_busy,
  output logic                 o_keys_valid,
  input  logic                 i_rk_rd,
  input  logic [3:0]           i_rk_idx,
  output logic                 o_rk_valid,
  output logic [NB*WORD-1:0]   o_rk
);

  localparam int NR   = NK + 6;
  localparam int TOTW = NB * (NR + 1);

  localparam logic [5:0] c_LAST = 6'(TOTW - 1);
  localparam logic [2:0] c_NKM1 = 3'(NK - 1);
  localparam logic [3:0] c_NR   = 4'(NR);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (b^254, which maps 0 to 0)
  // followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [5:0]      r_i;
  logic [2:0]      r_mod;          // i % NK, maintained by wrap-around counting
  logic [7:0]      r_rcon;
  logic [WORD-1:0] r_win [NK];     // r_win[NK-1] = w[i-1], r_win[0] = w[i-NK]
  logic [WORD-1:0] r_buf [TOTW];
  logic [WORD-1:0] w_key_word [NK];
  logic            w_accept;
  logic [WORD-1:0] w_prev;
  logic [WORD-1:0] w_sb_in;
  logic [WORD-1:0] w_sb_out;
  logic [WORD-1:0] w_f;
  logic [WORD-1:0] w_new;
  logic [7:0]      w_rcon_nxt;
  logic            w_rd_ok;
  logic [5:0]      w_base;

  generate
    for (genvar g = 0; g < NK; g++) begin : g_keyw
      assign w_key_word[g] = i_key[(NK-g)*WORD-1 -: WORD];
    end
  endgenerate

  assign w_accept = i_key_valid && o_key_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_EXPAND;
      S_EXPAND: if (r_i == c_LAST) w_state_nxt = S_DONE;
      S_DONE:   if (w_accept) w_state_nxt = S_EXPAND;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_key_ready  = 1'b1;
    o_busy       = 1'b0;
    o_keys_valid = 1'b0;
    case (r_state)
      S_EXPAND: begin
        o_key_ready = 1'b0;
        o_busy      = 1'b1;
      end
      S_DONE:   o_keys_valid = 1'b1;
      default:  ;
    endcase
  end

  // ---------------- shared g()/SubWord datapath ----------------
  always_comb begin
    w_prev     = r_win[NK-1];
    w_sb_in    = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sb_out   = {sbox(w_sb_in[31:24]), sbox(w_sb_in[23:16]),
                  sbox(w_sb_in[15:8]),  sbox(w_sb_in[7:0])};
    w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    if (r_mod == 3'd0)                  w_f = w_sb_out ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_mod == 3'd4)  w_f = w_sb_out;
    else                                w_f = w_prev;
    w_new = w_f ^ r_win[0];
  end

  // ---------------- counters and sliding window ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i    <= '0;
      r_mod  <= '0;
      r_rcon <= 8'h01;
      for (int j = 0; j < NK; j++) r_win[j] <= '0;
    end else if (w_accept) begin
      r_i    <= 6'(NK);
      r_mod  <= '0;
      r_rcon <= 8'h01;
      for (int j = 0; j < NK; j++) r_win[j] <= w_key_word[j];
    end else if (r_state == S_EXPAND) begin
      r_i   <= r_i + 6'd1;
      r_mod <= (r_mod == c_NKM1) ? 3'd0 : r_mod + 3'd1;
      if (r_mod == 3'd0) r_rcon <= w_rcon_nxt;
      for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
      r_win[NK-1] <= w_new;
    end
  end

  // ---------------- round-key buffer (not reset) ----------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < NK; j++) r_buf[j] <= w_key_word[j];
    end else if (r_state == S_EXPAND) begin
      r_buf[r_i] <= w_new;
    end
  end

  // ---------------- round-key read port ----------------
  // The buffer write of a new key lands at the same edge as this read, so a
  // read coinciding with a key accept in DONE still returns the old key.
  assign w_rd_ok = i_rk_rd && o_keys_valid && (i_rk_idx <= c_NR);
  assign w_base  = {i_rk_idx, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_rk_valid <= 1'b0;
      o_rk       <= '0;
    end else begin
      o_rk_valid <= w_rd_ok;
      if (w_rd_ok) begin
        for (int j = 0; j < NB; j++)
          o_rk[(NB-j)*WORD-1 -: WORD] <= r_buf[w_base + 6'(j)];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keysched_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keysched_seq
//  Purpose  : Directed self-checking bench for keysched_seq with one
//             instance each for AES-128, AES-192 and AES-256.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keysched_seq;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] rk1_exp [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic         clk;
  logic         rst;
  logic [2:0]   kv;
  logic [2:0]   rd;
  logic [11:0]  idx;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  wire  [2:0]   rdy;
  wire  [2:0]   bsy;
  wire  [2:0]   kval;
  wire  [2:0]   rkv;
  wire  [127:0] rk0;
  wire  [127:0] rk1;
  wire  [127:0] rk2;

  int n_cmp = 0;
  int n_err = 0;

  keysched_seq #(.WORD(32), .NB(4), .NK(4)) u_k4 (
    .clk(clk), .rst(rst), .i_key_valid(kv[0]), .i_key(key4),
    .o_key_ready(rdy[0]), .o_busy(bsy[0]), .o_keys_valid(kval[0]),
    .i_rk_rd(rd[0]), .i_rk_idx(idx[3:0]), .o_rk_valid(rkv[0]), .o_rk(rk0));

  keysched_seq #(.WORD(32), .NB(4), .NK(6)) u_k6 (
    .clk(clk), .rst(rst), .i_key_valid(kv[1]), .i_key(key6),
    .o_key_ready(rdy[1]), .o_busy(bsy[1]), .o_keys_valid(kval[1]),
    .i_rk_rd(rd[1]), .i_rk_idx(idx[7:4]), .o_rk_valid(rkv[1]), .o_rk(rk1));

  keysched_seq #(.WORD(32), .NB(4), .NK(8)) u_k8 (
    .clk(clk), .rst(rst), .i_key_valid(kv[2]), .i_key(key8),
    .o_key_ready(rdy[2]), .o_busy(bsy[2]), .o_keys_valid(kval[2]),
    .i_rk_rd(rd[2]), .i_rk_idx(idx[11:8]), .o_rk_valid(rkv[2]), .o_rk(rk2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rk_of(input int n);
    return (n == 0) ? rk0 : (n == 1) ? rk1 : rk2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // key argument is MSB-aligned in 256 bits
  task automatic start(input int n, input logic [255:0] k);
    case (n)
      0:       key4 = k[255:128];
      1:       key6 = k[255:64];
      default: key8 = k;
    endcase
    kv[n] = 1'b1;
    tick();
    kv[n] = 1'b0;
  endtask

  task automatic wait_done(input int n, input int exp_cycles, input string tag);
    int m;
    m = 0;
    while (!kval[n] && m < 200) begin
      tick();
      m++;
    end
    chk(tag, 128'(m), 128'(exp_cycles));
  endtask

  task automatic rdo(input int n, input int r);
    rd[n] = 1'b1;
    idx[n*4 +: 4] = 4'(r);
    tick();
    rd[n] = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    kv   = '0;
    rd   = '0;
    idx  = '0;
    key4 = '0;
    key6 = '0;
    key8 = '0;
    tick();
    tick();

    // reset state of every instance
    for (int n = 0; n < 3; n++) begin
      chk("rst_ready", 128'(rdy[n]), 128'(1));
      chk("rst_busy",  128'(bsy[n]), 128'(0));
      chk("rst_kval",  128'(kval[n]), 128'(0));
      chk("rst_rkv",   128'(rkv[n]), 128'(0));
      chk("rst_rk",    rk_of(n), 128'h0);
    end
    rst = 1'b1;
    tick();

    // T1 / T4 : AES-128
    start(0, {K1, 128'h0});
    chk("t1_busy",  128'(bsy[0]), 128'(1));
    chk("t1_ready", 128'(rdy[0]), 128'(0));
    rdo(0, 0);
    chk("t4_early_rkv", 128'(rkv[0]), 128'(0));
    chk("t4_early_rk",  rk0, 128'h0);
    wait_done(0, 39, "t1_latency");
    chk("t1_done_ready", 128'(rdy[0]), 128'(1));
    chk("t1_done_busy",  128'(bsy[0]), 128'(0));
    rdo(0, 11);
    chk("t4_idx11_rkv", 128'(rkv[0]), 128'(0));
    chk("t4_idx11_rk",  rk0, 128'h0);
    for (int r = 0; r <= 10; r++) begin
      rd[0] = 1'b1;
      idx[3:0] = 4'(r);
      tick();
      chk("t4_b2b_rkv", 128'(rkv[0]), 128'(1));
      chk("t1_rk",      rk0, rk1_exp[r]);
    end
    rd[0] = 1'b0;
    tick();
    chk("t4_pulse_end", 128'(rkv[0]), 128'(0));

    // T2 : AES-192
    start(1, {K2, 64'h0});
    wait_done(1, 46, "t2_latency");
    rdo(1, 0);
    chk("t2_rk0", rk1, K2[191:64]);
    rdo(1, 1);
    chk("t2_w4w5", 128'(rk1[127:64]), 128'(64'h62f8ead2522c6b7b));
    chk("t2_w6",   128'(rk1[63:32]),  128'(32'hfe0c91f7));
    rdo(1, 12);
    chk("t2_rkv12", 128'(rkv[1]), 128'(1));
    chk("t2_w51",  128'(rk1[31:0]), 128'(32'h01002202));
    rdo(1, 13);
    chk("t2_idx13_rkv", 128'(rkv[1]), 128'(0));

    // T3 : AES-256
    start(2, K3);
    wait_done(2, 52, "t3_latency");
    rdo(2, 1);
    chk("t3_rk1", rk2, K3[127:0]);
    rdo(2, 2);
    chk("t3_w8",  128'(rk2[127:96]), 128'(32'h9ba35411));
    rdo(2, 3);
    chk("t3_w12", 128'(rk2[127:96]), 128'(32'ha8b09c1a));
    rdo(2, 14);
    chk("t3_rkv14", 128'(rkv[2]), 128'(1));
    chk("t3_rk14", rk2, 128'hfe4890d1e6188d0b046df344706c631e);

    // T5 : new key in DONE with a simultaneous read of round 10
    key4 = KC;
    kv[0] = 1'b1;
    rd[0] = 1'b1;
    idx[3:0] = 4'd10;
    tick();
    kv[0] = 1'b0;
    rd[0] = 1'b0;
    chk("t5_old_rkv",  128'(rkv[0]), 128'(1));
    chk("t5_old_rk10", rk0, rk1_exp[10]);
    chk("t5_kval_drop", 128'(kval[0]), 128'(0));
    chk("t5_busy",     128'(bsy[0]), 128'(1));
    wait_done(0, 40, "t5_latency");
    rdo(0, 1);
    chk("t5_new_rk1",  rk0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    rdo(0, 10);
    chk("t5_new_rk10", rk0, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // T6 : asynchronous reset in the middle of an expansion
    start(0, {K1, 128'h0});
    repeat (20) tick();
    chk("t6_busy_pre", 128'(bsy[0]), 128'(1));
    rst = 1'b0;
    #1;
    chk("t6_ready", 128'(rdy[0]), 128'(1));
    chk("t6_busy",  128'(bsy[0]), 128'(0));
    chk("t6_kval",  128'(kval[0]), 128'(0));
    chk("t6_rk",    rk0, 128'h0);
    tick();
    rst = 1'b1;
    tick();
    start(0, {K1, 128'h0});
    wait_done(0, 40, "t6_latency");
    rdo(0, 0);
    chk("t6_rk0", rk0, rk1_exp[0]);
    rdo(0, 1);
    chk("t6_rk1", rk0, rk1_exp[1]);
    rdo(0, 10);
    chk("t6_rk10", rk0, rk1_exp[10]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
